// File: rtl/minute_second_timebase.sv
// minute_second_timebase
// Sub-hour timebase. It divides clk down to seconds and keeps a minutes:seconds
// count from 00:00 to 59:59. It emits a one-cycle hour_tick on each 59:59 -> 00:00
// rollover, which feeds the enable of the downstream 24-hour counter.
// Run/stop control, plus a set port that loads clamped minutes and seconds.
module minute_second_timebase #(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       set_en,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic       sec_tick,
    output logic       hour_tick,
    output logic       running
);

    // Prescaler width; the guard keeps the width legal if someone passes 1.
    localparam int              PRE_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]       MAX_CNT  = 6'd59;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_SET  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic             sec_tick_q, sec_tick_d;
    logic             hour_tick_q, hour_tick_d;
    logic             running_q;

    // A load value above 59 saturates. All six bits take part in the compare.
    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > MAX_CNT) ? MAX_CNT : v;
    endfunction

    // Next-state logic. set_en has priority from any state.
    always_comb begin
        // NOTE: each always_comb output gets a default before any branch. A path
        // that leaves a variable unassigned would otherwise infer a latch.
        state_d = state_q;
        if (set_en) begin
            state_d = ST_SET;
        end else begin
            unique case (state_q)
                ST_SET:  state_d = ST_STOP;
                ST_STOP: if (run)  state_d = ST_RUN;
                ST_RUN:  if (!run) state_d = ST_STOP;
                default: state_d = ST_STOP;
            endcase
        end
    end

    // Counter datapath. A load overrides everything. Counting happens only on an
    // edge where the state stays in RUN, so a falling run never increments.
    always_comb begin
        pre_d       = pre_q;
        sec_d       = sec_q;
        min_d       = min_q;
        sec_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        if (set_en) begin
            pre_d = '0;
            sec_d = clamp59(set_sec);
            min_d = clamp59(set_min);
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (pre_q == PRE_LAST) begin
                pre_d      = '0;
                sec_tick_d = 1'b1;
                if (sec_q == MAX_CNT) begin
                    sec_d = 6'd0;
                    if (min_q == MAX_CNT) begin
                        min_d       = 6'd0;
                        hour_tick_d = 1'b1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // State and counter registers. An asynchronous reset also clears a pending tick.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments. Every register then
        // samples the pre-edge values, whatever order the statements are in.
        if (reset) begin
            state_q     <= ST_STOP;
            pre_q       <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            sec_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            sec_tick_q  <= sec_tick_d;
            hour_tick_q <= hour_tick_d;
            running_q   <= (state_d == ST_RUN);
        end
    end

    assign seconds   = sec_q;
    assign minutes   = min_q;
    assign sec_tick  = sec_tick_q;
    assign hour_tick = hour_tick_q;
    assign running   = running_q;

endmodule

// File: tb/tb_minute_second_timebase.sv
// Testbench for minute_second_timebase with TICKS_PER_SEC = 4.
// The reference model tracks the whole time as one elapsed-tick count, t, in
// the range 0 .. 3600*T-1. Minutes, seconds and ticks are derived from t by
// division. A compare process checks every output on every falling edge.
// Directed scenarios add hand-computed literal expectations. A randomized phase
// follows them.
module tb_minute_second_timebase;

    localparam int T    = 4;
    localparam int HOUR = 3600 * T;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       set_en;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       sec_tick;
    logic       hour_tick;
    logic       running;

    int errors = 0;
    int checks = 0;

    minute_second_timebase #(.TICKS_PER_SEC(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .set_en    (set_en),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .seconds   (seconds),
        .minutes   (minutes),
        .sec_tick  (sec_tick),
        .hour_tick (hour_tick),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 = stopped, 1 = running, 2 = loading
    int t    = 0;
    int mode = 0;
    bit m_sec_tick  = 0;
    bit m_hour_tick = 0;

    function automatic int clamp(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = 0;
            mode = 0;
            m_sec_tick = 0;
            m_hour_tick = 0;
        end else begin
            m_sec_tick = 0;
            m_hour_tick = 0;
            if (set_en) begin
                t = (clamp(int'(set_min)) * 60 + clamp(int'(set_sec))) * T;
                mode = 2;
            end else if (mode == 2) begin
                mode = 0;
            end else if (mode == 0) begin
                if (run) mode = 1;
            end else if (!run) begin
                mode = 0;
            end else begin
                t = (t + 1) % HOUR;
                m_sec_tick  = (t % T) == 0;
                m_hour_tick = (t == 0);
            end
        end
    end

    // Per-cycle compare against the model, on the edge away from the active one.
    always @(negedge clk) begin
        check("seconds",   int'(seconds),   (t / T) % 60);
        check("minutes",   int'(minutes),   t / (60 * T));
        check("sec_tick",  int'(sec_tick),  int'(m_sec_tick));
        check("hour_tick", int'(hour_tick), int'(m_hour_tick));
        check("running",   int'(running),   (mode == 1) ? 1 : 0);
    end

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; set_en = 1'b0; set_min = 6'd0; set_sec = 6'd0;
        tick(2);
        reset = 1'b0;

        // Reset state and the first second.
        tick(3);
        check("idle_seconds", int'(seconds), 0);
        check("idle_running", int'(running), 0);
        run = 1'b1;
        tick(1);
        check("run_running", int'(running), 1);
        tick(3);
        check("pre_first_tick", int'(sec_tick), 0);
        tick(1);
        check("first_sec", int'(seconds), 1);
        check("first_sec_tick", int'(sec_tick), 1);
        tick(1);
        check("first_tick_one_cycle", int'(sec_tick), 0);

        // Hour rollover from 59:58.
        set_en = 1'b1; set_min = 6'd59; set_sec = 6'd58;
        tick(1);
        check("load_min", int'(minutes), 59);
        check("load_sec", int'(seconds), 58);
        set_en = 1'b0;
        tick(2);                         // SET -> STOP, then STOP -> RUN
        tick(4);
        check("roll_5959_sec", int'(seconds), 59);
        check("roll_5959_tick", int'(sec_tick), 1);
        tick(3);
        check("roll_no_hour_early", int'(hour_tick), 0);
        tick(1);
        check("roll_min", int'(minutes), 0);
        check("roll_sec", int'(seconds), 0);
        check("roll_hour_tick", int'(hour_tick), 1);
        check("roll_sec_tick", int'(sec_tick), 1);

        // Asynchronous reset while hour_tick is high.
        #2 reset = 1'b1;
        #1;
        check("areset_hour_tick", int'(hour_tick), 0);
        check("areset_sec_tick", int'(sec_tick), 0);
        check("areset_running", int'(running), 0);
        run = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(6);
        check("post_reset_idle", int'(running), 0);
        check("post_reset_sec", int'(seconds), 0);

        // Asynchronous reset mid-count at 12:34.
        set_en = 1'b1; set_min = 6'd12; set_sec = 6'd34;
        tick(1);
        set_en = 1'b0; run = 1'b1;
        tick(3);
        check("at_1234_min", int'(minutes), 12);
        check("at_1234_sec", int'(seconds), 34);
        #2 reset = 1'b1;
        #1;
        check("areset_1234_min", int'(minutes), 0);
        check("areset_1234_sec", int'(seconds), 0);
        run = 1'b0;
        tick(1);
        reset = 1'b0;

        // Pause at 00:03 with pre = 2, then resume.
        run = 1'b1;
        tick(1);
        tick(14);
        check("pause_at_sec", int'(seconds), 3);
        run = 1'b0;
        tick(11);
        check("pause_hold_sec", int'(seconds), 3);
        check("pause_running", int'(running), 0);
        run = 1'b1;
        tick(2);
        check("resume_no_tick_yet", int'(sec_tick), 0);
        tick(1);
        check("resume_tick", int'(sec_tick), 1);
        check("resume_sec", int'(seconds), 4);

        // Clamp of out-of-range load values.
        set_en = 1'b1; set_min = 6'd63; set_sec = 6'd60;
        tick(2);
        check("clamp_min", int'(minutes), 59);
        check("clamp_sec", int'(seconds), 59);
        check("clamp_in_set", int'(running), 0);
        set_en = 1'b0; run = 1'b0;
        tick(1);
        check("clamp_then_stop", int'(running), 0);

        // A load on the edge where 59:59 would wrap.
        run = 1'b1;
        tick(1);
        tick(3);
        set_en = 1'b1; set_min = 6'd0; set_sec = 6'd5;
        tick(1);
        check("setwrap_sec", int'(seconds), 5);
        check("setwrap_min", int'(minutes), 0);
        check("setwrap_hour_tick", int'(hour_tick), 0);
        check("setwrap_sec_tick", int'(sec_tick), 0);
        set_en = 1'b0;

        // Randomized phase, biased toward loads near the hour boundary.
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            set_en = (r < 30);
            if (r < 30) begin
                set_min = ($urandom_range(0, 1) == 1) ? 6'd59 : 6'($urandom_range(0, 63));
                set_sec = 6'($urandom_range(56, 63));
                if ($urandom_range(0, 3) == 0) set_sec = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 99) < 4) run = ~run;
            if (r >= 997) begin
                #2 reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end else begin
                tick(1);
            end
        end

        set_en = 1'b0;
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
